// File: rtl/norm_ctrl_pkg.sv
// Shared constants and FSM state type for the lane-norm controller.
package norm_ctrl_pkg;

  localparam int unsigned NLANES = 18;
  localparam int unsigned LANE_W = 10;
  localparam int unsigned MAG_W  = 8;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned ROOT_W = 8;
  localparam logic [ACC_W-1:0] ACC_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StRoot,
    StHold
  } state_e;

endpackage

// File: rtl/isqrt_seq.sv
// Bit-serial integer square root: one result bit per cycle, MSB first.
module isqrt_seq
  import norm_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ACC_W-1:0]  operand,
  output logic [ROOT_W-1:0] root,
  output logic              done
);

  logic              active_q, active_d;
  logic [2:0]        bit_q, bit_d;
  logic [ROOT_W-1:0] root_q, root_d;
  logic [ROOT_W-1:0] trial;
  logic [ACC_W-1:0]  trial_sq;

  // operand is read live; the caller keeps it stable until done.
  always_comb begin
    trial    = root_q | (ROOT_W'(1) << bit_q);
    trial_sq = ACC_W'(trial) * ACC_W'(trial);
    active_d = active_q;
    bit_d    = bit_q;
    root_d   = root_q;
    if (start) begin
      active_d = 1'b1;
      bit_d    = 3'd7;
      root_d   = '0;
    end else if (active_q) begin
      if (trial_sq <= operand) begin
        root_d = trial;
      end
      if (bit_q == 3'd0) begin
        active_d = 1'b0;
      end else begin
        bit_d = bit_q - 3'd1;
      end
    end
  end

  // Final root is offered in the cycle of the last decision so the caller can
  // capture it on the same edge that retires bit 0.
  assign root = root_d;
  assign done = active_q && (bit_q == 3'd0) && !start;

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      bit_q    <= '0;
      root_q   <= '0;
    end else begin
      active_q <= active_d;
      bit_q    <= bit_d;
      root_q   <= root_d;
    end
  end

endmodule

// File: rtl/norm_ctrl.sv
// Euclidean-norm controller: serial saturating sum of squares, then bit-serial sqrt.
module norm_ctrl #(
  parameter int unsigned NLANES = norm_ctrl_pkg::NLANES,
  parameter int unsigned LANE_W = norm_ctrl_pkg::LANE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [NLANES*LANE_W-1:0] weights,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [8:0]               norm,
  output logic                     sat,
  output logic                     busy
);
  import norm_ctrl_pkg::*;

  localparam int unsigned LaneIdxW = (NLANES > 1) ? $clog2(NLANES) : 1;

  state_e                         state_q, state_d;
  logic [NLANES-1:0][LANE_W-1:0]  weights_q, weights_d;
  logic [ACC_W-1:0]               acc_q, acc_d;
  logic                           acc_sat_q, acc_sat_d;
  logic [LaneIdxW-1:0]            lane_q, lane_d;
  logic [ROOT_W-1:0]              norm_q, norm_d;
  logic                           sat_q, sat_d;

  logic [MAG_W-1:0]  mag;
  logic [ACC_W-1:0]  square;
  logic [ACC_W:0]    sum;
  logic              root_start;
  logic              root_done;
  logic [ROOT_W-1:0] root_val;

  isqrt_seq u_isqrt (
    .clk     (clk),
    .rst     (rst),
    .start   (root_start),
    .operand (acc_q),
    .root    (root_val),
    .done    (root_done)
  );

  always_comb begin
    mag        = weights_q[lane_q][MAG_W-1:0];
    square     = ACC_W'(mag) * ACC_W'(mag);
    sum        = {1'b0, acc_q} + {1'b0, square};
    state_d    = state_q;
    weights_d  = weights_q;
    acc_d      = acc_q;
    acc_sat_d  = acc_sat_q;
    lane_d     = lane_q;
    norm_d     = norm_q;
    sat_d      = sat_q;
    root_start = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          weights_d = weights;
          acc_d     = '0;
          acc_sat_d = 1'b0;
          lane_d    = '0;
          state_d   = StAccum;
        end
      end
      StAccum: begin
        if (acc_sat_q || sum[ACC_W]) begin
          acc_d     = ACC_MAX;
          acc_sat_d = 1'b1;
        end else begin
          acc_d = sum[ACC_W-1:0];
        end
        if (lane_q == LaneIdxW'(NLANES - 1)) begin
          lane_d     = '0;
          root_start = 1'b1;
          state_d    = StRoot;
        end else begin
          lane_d = lane_q + LaneIdxW'(1);
        end
      end
      StRoot: begin
        if (root_done) begin
          norm_d  = root_val;
          sat_d   = acc_sat_q;
          state_d = StHold;
        end
      end
      StHold: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      weights_q <= '0;
      acc_q     <= '0;
      acc_sat_q <= 1'b0;
      lane_q    <= '0;
      norm_q    <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      weights_q <= weights_d;
      acc_q     <= acc_d;
      acc_sat_q <= acc_sat_d;
      lane_q    <= lane_d;
      norm_q    <= norm_d;
      sat_q     <= sat_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign res_valid = (state_q == StHold);
  assign norm      = {1'b0, norm_q};
  assign sat       = sat_q;

endmodule

// File: doc/norm_ctrl.md
NORM_CTRL -- requirements
Module: norm_ctrl

Interface
REQ-001 Parameter NLANES, default 18: number of weight lanes.
REQ-002 Parameter LANE_W, default 10: lane stride in bits; bits [7:0] of each lane are the magnitude, upper bits ignored.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 weights  input  NLANES*LANE_W (180)  lane i at [i*LANE_W+7 : i*LANE_W].
REQ-008 res_valid  output  1  result present.
REQ-009 res_ready  input  1  consumer accepts result.
REQ-010 norm  output  9  {1'b0, floor(sqrt(saturated sum of squares))}.
REQ-011 sat  output  1  accumulation saturated during this request.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states IDLE, ACCUM, ROOT, HOLD; only these four encodings are reachable.
REQ-014 req_ready SHALL equal (state==IDLE); accept = req_valid & req_ready; on accept, weights are registered, acc:=0, sat:=0, lane index:=0, state:=ACCUM.
REQ-015 weights SHALL be sampled only on the accepting edge; later input changes have no effect on that request.
REQ-016 ACCUM: one lane per cycle, lane 0 first; a single shared 8x8 multiplier computes mag*mag (16-bit).
REQ-017 Accumulator is 16 bits; if acc + square > 65535, acc:=65535 and sat:=1, else acc:=acc+square; once saturated it stays 65535.
REQ-018 After lane NLANES-1 is added, state:=ROOT, root:=0, bit index:=7.
REQ-019 ROOT: one bit per cycle, bit 7 down to 0: trial = root | (1<<b); if trial*trial <= acc then root:=trial; after bit 0, state:=HOLD.
REQ-020 HOLD: res_valid=1; norm and sat stable; on res_valid & res_ready, state:=IDLE.
REQ-021 Latency: res_valid rises exactly NLANES+8 (26) cycles after the accepting edge; with res_ready held high, req_ready returns one cycle after res_valid rises.
REQ-022 res_valid SHALL be 0 in all states except HOLD; norm/sat retain the last result outside HOLD.
REQ-023 req_valid during ACCUM/ROOT/HOLD is ignored (no queueing); requester holds it until req_ready.
REQ-024 res_ready outside HOLD has no effect.
REQ-025 Maximum result 255 (norm[8] always 0); acc=0 yields norm=0.

Reset
REQ-026 On rst: state:=IDLE, req_ready=1, res_valid=0, busy=0, norm=0, sat=0, acc=0, root=0, indices=0.
REQ-027 rst asserted in any state, including mid-ACCUM or mid-ROOT, SHALL abort the request with no result ever presented; rst has priority over accept.

Structure
REQ-028 Shared package holds: NLANES, LANE_W, MAG_W=8, ACC_W=16, ROOT_W=8, ACC_MAX=65535, FSM state enum.
REQ-029 Iterative root extraction SHALL be a sub-module isqrt_seq (start, 16-bit operand in, 8-bit root out, done); the multiplier and saturating accumulator stay in norm_ctrl.

Verification
REQ-030 All lanes 0 -> norm=9'd0, sat=0, res_valid at cycle 26 after accept.
REQ-031 lane0=3, lane1=4, rest 0 -> acc=25, norm=9'd5, sat=0.
REQ-032 All lanes 8'd255 -> sat=1, acc=65535, norm=9'd255; lane0=10'h3FF with others 0 -> acc=65025, norm=9'd255, sat=0 (bits 9:8 ignored).
REQ-033 lane0=255, lane1=22 -> acc=65509, norm=9'd255, sat=0; lane0=1, lane1=1, lane2=1 -> norm=9'd1.
REQ-034 res_ready held low for 10 cycles in HOLD -> res_valid, norm, sat stable, req_ready=0, a pending req_valid not accepted until one cycle after the res handshake.
REQ-035 rst pulsed at accept+5 (mid-ACCUM) then new request lane0=3, lane1=4 -> no res_valid from the aborted request; new result norm=9'd5 at 26 cycles after its accept.
